mfc_memory_unit: RTL and testbench



---
 rtl/mfc_memory_unit.sv | 152 +++++++++++++++
 tb/tb_mfc_memory_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mfc_memory_unit.sv
`timescale 1ns/1ps
// Byte-addressable memory with Enable/MFC four-phase handshake, big-endian byte/half/word transfers.
// Latency: access and MFC at edge accept+WAIT_CYCLES+1; DataOut valid with MFC.
// Backpressure: requester holds Enable until MFC; the next request is accepted only after Enable is seen low in DONE.
module mfc_memory_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Enable,
    input  logic        ReadWrite,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [1:0]  wordSelector,
    input  logic        SignExt,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        AlignErr,
    output logic        Busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             din_q;
    logic [1:0]              size_q;
    logic                    sx_q;

    logic [7:0]              mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   addr1;
    logic [ADDR_WIDTH-1:0]   addr2;
    logic [ADDR_WIDTH-1:0]   addr3;
    logic                    is_half;
    logic                    is_word;
    logic                    misaligned;
    logic                    do_access;
    logic                    wr_en;
    logic [31:0]             rd_val;

    // Only the low ADDR_WIDTH address bits select a byte; the rest are don't-care.
    generate
        if (ADDR_WIDTH < 32) begin : g_addr_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^Address[31:ADDR_WIDTH];
        end
    endgenerate

    // Successive byte lanes wrap modulo the memory depth.
    assign addr1 = addr_q + ADDR_WIDTH'(1);
    assign addr2 = addr_q + ADDR_WIDTH'(2);
    assign addr3 = addr_q + ADDR_WIDTH'(3);

    // wordSelector 11 behaves as a byte transfer.
    assign is_half    = (size_q == 2'b01);
    assign is_word    = (size_q == 2'b10);
    assign misaligned = (is_half & addr_q[0]) | (is_word & (addr_q[1:0] != 2'b00));
    assign do_access  = (state == WAIT) && (cnt == 4'd0);
    assign wr_en      = do_access && !rw_q && !misaligned;

    // Assemble big-endian read data, right-justified, with optional sign fill.
    always_comb begin
        rd_val = 32'd0;
        if (is_word) begin
            rd_val = {mem[addr_q], mem[addr1], mem[addr2], mem[addr3]};
        end else if (is_half) begin
            rd_val = {{16{sx_q & mem[addr_q][7]}}, mem[addr_q], mem[addr1]};
        end else begin
            rd_val = {{24{sx_q & mem[addr_q][7]}}, mem[addr_q]};
        end
    end

    // Storage array: no reset, written only on an aligned write access.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (is_word) begin
                mem[addr_q] <= din_q[31:24];
                mem[addr1]  <= din_q[23:16];
                mem[addr2]  <= din_q[15:8];
                mem[addr3]  <= din_q[7:0];
            end else if (is_half) begin
                mem[addr_q] <= din_q[15:8];
                mem[addr1]  <= din_q[7:0];
            end else begin
                mem[addr_q] <= din_q[7:0];
            end
        end
    end

    // Handshake FSM: latch request, count wait states, complete, wait for Enable to drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= 32'd0;
            size_q   <= 2'b00;
            sx_q     <= 1'b0;
            DataOut  <= 32'd0;
            MFC      <= 1'b0;
            AlignErr <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Enable) begin
                        rw_q   <= ReadWrite;
                        addr_q <= Address[ADDR_WIDTH-1:0];
                        din_q  <= DataIn;
                        size_q <= wordSelector;
                        sx_q   <= SignExt;
                        cnt    <= 4'(WAIT_CYCLES);
                        Busy   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (misaligned) begin
                            AlignErr <= 1'b1;
                        end else if (rw_q) begin
                            DataOut <= rd_val;
                        end
                        MFC   <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!Enable) begin
                        MFC      <= 1'b0;
                        AlignErr <= 1'b0;
                        Busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfc_memory_unit.sv
`timescale 1ns/1ps
// Bench for mfc_memory_unit: two instances (2 and 0 wait states) against a byte-array model.
// Latency: checks MFC arrives exactly WAIT_CYCLES+1 edges after acceptance.
// Backpressure: exercises Enable held in DONE and minimum back-to-back spacing.
module tb_mfc_memory_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] din = 32'd0;
    logic [1:0]  ws = 2'b00;
    logic        sx = 1'b0;

    logic [31:0] dout_a, dout_b;
    logic        mfc_a, mfc_b, err_a, err_b, busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  model [2][256];
    logic [31:0] last_dout [2];

    always #5 clk = ~clk;

    mfc_memory_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .Enable(en_a), .ReadWrite(rw), .Address(addr),
        .DataIn(din), .wordSelector(ws), .SignExt(sx),
        .DataOut(dout_a), .MFC(mfc_a), .AlignErr(err_a), .Busy(busy_a)
    );

    mfc_memory_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .Enable(en_b), .ReadWrite(rw), .Address(addr),
        .DataIn(din), .wordSelector(ws), .SignExt(sx),
        .DataOut(dout_b), .MFC(mfc_b), .AlignErr(err_b), .Busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_dout(input int sel);
        return (sel == 0) ? dout_a : dout_b;
    endfunction
    function automatic logic out_mfc(input int sel);
        return (sel == 0) ? mfc_a : mfc_b;
    endfunction
    function automatic logic out_err(input int sel);
        return (sel == 0) ? err_a : err_b;
    endfunction
    function automatic logic out_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    // Big-endian value of n bytes starting at a; sign handled arithmetically.
    function automatic logic [31:0] model_read(input int sel, input logic [7:0] a, input int n, input logic s);
        longint v;
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(model[sel][8'(int'(a) + i)]);
        if (s && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_write(input int sel, input logic [7:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) model[sel][8'(int'(a) + i)] = 8'(d >> (8 * (n - 1 - i)));
    endtask

    task automatic set_en(input int sel, input logic v);
        if (sel == 0) en_a = v;
        else en_b = v;
    endtask

    // One complete handshake; hold = extra cycles Enable stays high after MFC.
    task automatic txn(input int sel, input logic t_rw, input logic [31:0] t_addr, input logic [31:0] t_din,
                       input logic [1:0] t_ws, input logic t_sx, input int hold);
        int          n, lat, wc;
        logic [7:0]  a;
        logic        mis;
        logic [31:0] exp_d, r;
        n   = (t_ws == 2'b10) ? 4 : (t_ws == 2'b01) ? 2 : 1;
        a   = t_addr[7:0];
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        wc  = (sel == 0) ? 2 : 0;
        rw = t_rw; addr = t_addr; din = t_din; ws = t_ws; sx = t_sx;
        set_en(sel, 1'b1);
        @(posedge clk); #1;
        chk("busy_on_accept", 32'(out_busy(sel)), 32'd1);
        // Inputs other than Enable must be ignored once accepted.
        r = $urandom;
        rw = r[0]; ws = r[2:1]; sx = r[3]; addr = $urandom; din = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_mfc(sel) && lat < 20);
        chk("mfc_latency", 32'(lat), 32'(wc + 1));
        if (mis) begin
            exp_d = last_dout[sel];
        end else if (t_rw) begin
            exp_d = model_read(sel, a, n, t_sx);
            last_dout[sel] = exp_d;
        end else begin
            model_write(sel, a, n, t_din);
            exp_d = last_dout[sel];
        end
        chk("align_err", 32'(out_err(sel)), 32'(mis));
        chk("data_out", out_dout(sel), exp_d);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("mfc_held", 32'(out_mfc(sel)), 32'd1);
        end
        set_en(sel, 1'b0);
        @(posedge clk); #1;
        chk("mfc_drop", 32'(out_mfc(sel)), 32'd0);
        chk("busy_drop", 32'(out_busy(sel)), 32'd0);
        chk("err_drop", 32'(out_err(sel)), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        last_dout[0] = 32'd0;
        last_dout[1] = 32'd0;

        @(posedge clk); #1;
        chk("rst_dout_a", dout_a, 32'd0);
        chk("rst_mfc_a", 32'(mfc_a), 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_dout_b", dout_b, 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Give both memories known contents.
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 64; w++) txn(s, 1'b0, 32'(w * 4), $urandom, 2'b10, 1'b0, 0);

        // Directed: word/byte/halfword big-endian reads with sign control.
        txn(0, 1'b0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0);
        txn(0, 1'b1, 32'h10, 32'h0, 2'b10, 1'b0, 0);
        chk("rd_word_10", dout_a, 32'hDEADBEEF);
        txn(0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 0);
        chk("rd_byte_10", dout_a, 32'h000000DE);
        txn(0, 1'b1, 32'h12, 32'h0, 2'b01, 1'b1, 0);
        chk("rd_half_12_sx", dout_a, 32'hFFFFBEEF);
        txn(0, 1'b1, 32'h12, 32'h0, 2'b01, 1'b0, 0);
        chk("rd_half_12_zx", dout_a, 32'h0000BEEF);
        txn(0, 1'b1, 32'h13, 32'h0, 2'b11, 1'b1, 0);
        chk("rd_byte_13_sx", dout_a, 32'hFFFFFFEF);

        // Misaligned accesses are flagged and suppressed.
        txn(0, 1'b0, 32'h21, 32'h11223344, 2'b10, 1'b0, 0);
        txn(0, 1'b1, 32'h20, 32'h0, 2'b10, 1'b0, 0);
        txn(0, 1'b1, 32'h05, 32'h0, 2'b01, 1'b0, 0);

        // Upper address bits are ignored.
        txn(0, 1'b0, 32'h000001FF, 32'h000000AB, 2'b00, 1'b0, 0);
        txn(0, 1'b1, 32'h000000FF, 32'h0, 2'b00, 1'b0, 0);
        chk("rd_byte_ff", dout_a, 32'h000000AB);

        // Reset in the middle of a write aborts it.
        txn(0, 1'b0, 32'h40, 32'h01020304, 2'b10, 1'b0, 0);
        rw = 1'b0; addr = 32'h40; din = 32'hCAFEF00D; ws = 2'b10; sx = 1'b0;
        en_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_in_wait", 32'(busy_a), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_mfc", 32'(mfc_a), 32'd0);
        chk("abort_dout", dout_a, 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        en_a = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        last_dout[0] = 32'd0;
        last_dout[1] = 32'd0;
        @(posedge clk); #1;
        txn(0, 1'b1, 32'h40, 32'h0, 2'b10, 1'b0, 0);
        chk("rd_after_abort", dout_a, 32'h01020304);

        // Zero wait states: back-to-back write/read, then Enable held in DONE.
        txn(1, 1'b0, 32'h80, 32'h55AA1234, 2'b10, 1'b0, 0);
        txn(1, 1'b1, 32'h80, 32'h0, 2'b10, 1'b0, 5);
        chk("b2b_rd", dout_b, 32'h55AA1234);

        // Randomized traffic on both instances.
        for (int k = 0; k < 150; k++) begin
            r = $urandom;
            txn(int'(r[8]), r[0], $urandom, $urandom, r[2:1], r[3], int'(r[5:4]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
